// File: rtl/adbg_jtag_tap_if.sv
// rtl/adbg_jtag_tap_if.sv - JTAG pin and debug strobe bundle around the TAP controller
interface adbg_jtag_tap_if;
  logic tms_i;
  logic tdi_i;
  logic tdo_o;
  logic tdo_oe_o;
  logic debug_tdo_i;
  logic test_logic_reset_o;
  logic run_test_idle_o;
  logic shift_dr_o;
  logic pause_dr_o;
  logic update_dr_o;
  logic capture_dr_o;
  logic debug_select_o;

  modport master (
    output tms_i, tdi_i, debug_tdo_i,
    input  tdo_o, tdo_oe_o, test_logic_reset_o, run_test_idle_o,
           shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o, debug_select_o
  );

  modport slave (
    input  tms_i, tdi_i, debug_tdo_i,
    output tdo_o, tdo_oe_o, test_logic_reset_o, run_test_idle_o,
           shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o, debug_select_o
  );
endinterface

// File: rtl/adbg_jtag_tap.sv
// rtl/adbg_jtag_tap.sv - IEEE 1149.1 TAP controller feeding the advanced debug interface
module adbg_jtag_tap #(
  parameter int                  IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h149511C3,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = 4'b0010,
  parameter logic [IR_WIDTH-1:0] DEBUG_INSTR  = 4'b1000,
  parameter logic [IR_WIDTH-1:0] BYPASS_INSTR = 4'b1111
) (
  input  logic                tck_i,
  input  logic                trstn_i,
  adbg_jtag_tap_if.slave      jtag
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } state_e;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] ir_latched_q, ir_latched_d;
  logic [31:0]         idcode_q, idcode_d;
  logic                bypass_q, bypass_d;
  logic                debug_select_q, debug_select_d;
  logic                tdo_q, tdo_d;
  logic                tdo_oe_q, tdo_oe_d;

  logic sel_idcode, sel_debug, sel_bypass;

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = jtag.tms_i ? TLR    : RTI;
      RTI:    state_d = jtag.tms_i ? SEL_DR : RTI;
      SEL_DR: state_d = jtag.tms_i ? SEL_IR : CAP_DR;
      CAP_DR: state_d = jtag.tms_i ? EX1_DR : SH_DR;
      SH_DR:  state_d = jtag.tms_i ? EX1_DR : SH_DR;
      EX1_DR: state_d = jtag.tms_i ? UPD_DR : PAU_DR;
      PAU_DR: state_d = jtag.tms_i ? EX2_DR : PAU_DR;
      EX2_DR: state_d = jtag.tms_i ? UPD_DR : SH_DR;
      UPD_DR: state_d = jtag.tms_i ? SEL_DR : RTI;
      SEL_IR: state_d = jtag.tms_i ? TLR    : CAP_IR;
      CAP_IR: state_d = jtag.tms_i ? EX1_IR : SH_IR;
      SH_IR:  state_d = jtag.tms_i ? EX1_IR : SH_IR;
      EX1_IR: state_d = jtag.tms_i ? UPD_IR : PAU_IR;
      PAU_IR: state_d = jtag.tms_i ? EX2_IR : PAU_IR;
      EX2_IR: state_d = jtag.tms_i ? UPD_IR : SH_IR;
      UPD_IR: state_d = jtag.tms_i ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  always_comb begin
    jtag.test_logic_reset_o = (state_q == TLR);
    jtag.run_test_idle_o    = (state_q == RTI);
    jtag.shift_dr_o         = (state_q == SH_DR);
    jtag.pause_dr_o         = (state_q == PAU_DR);
    jtag.update_dr_o        = (state_q == UPD_DR);
    jtag.capture_dr_o       = (state_q == CAP_DR);
    jtag.debug_select_o     = debug_select_q;
    jtag.tdo_o              = tdo_q;
    jtag.tdo_oe_o           = tdo_oe_q;
  end

  // Unlisted opcodes fall back to BYPASS so an unknown IR never breaks the scan chain.
  always_comb begin
    sel_idcode = (ir_latched_q == IDCODE_INSTR);
    sel_debug  = (ir_latched_q == DEBUG_INSTR);
    sel_bypass = (ir_latched_q == BYPASS_INSTR) || !(sel_idcode || sel_debug);
  end

  always_comb begin
    ir_shift_d   = ir_shift_q;
    ir_latched_d = ir_latched_q;
    idcode_d     = idcode_q;
    bypass_d     = bypass_q;

    case (state_q)
      CAP_IR: ir_shift_d = IR_CAPTURE;
      SH_IR:  ir_shift_d = {jtag.tdi_i, ir_shift_q[IR_WIDTH-1:1]};
      UPD_IR: ir_latched_d = ir_shift_q;
      CAP_DR: begin
        bypass_d = 1'b0;
        if (sel_idcode) idcode_d = IDCODE_VALUE;
      end
      SH_DR: begin
        bypass_d = jtag.tdi_i;
        if (sel_idcode) idcode_d = {jtag.tdi_i, idcode_q[31:1]};
      end
      default: ;
    endcase

    // Forcing on entry keeps IDCODE latched for every cycle spent in Test-Logic-Reset.
    if (state_d == TLR) ir_latched_d = IDCODE_INSTR;
    debug_select_d = (ir_latched_d == DEBUG_INSTR);
  end

  always_comb begin
    tdo_d    = tdo_q;
    tdo_oe_d = 1'b0;
    if (state_q == SH_IR) begin
      tdo_d    = ir_shift_q[0];
      tdo_oe_d = 1'b1;
    end else if (state_q == SH_DR) begin
      tdo_oe_d = 1'b1;
      if (sel_idcode)      tdo_d = idcode_q[0];
      else if (sel_debug)  tdo_d = jtag.debug_tdo_i;
      else if (sel_bypass) tdo_d = bypass_q;
    end
  end

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      ir_shift_q     <= '0;
      ir_latched_q   <= IDCODE_INSTR;
      idcode_q       <= IDCODE_VALUE;
      bypass_q       <= 1'b0;
      debug_select_q <= 1'b0;
    end else begin
      ir_shift_q     <= ir_shift_d;
      ir_latched_q   <= ir_latched_d;
      idcode_q       <= idcode_d;
      bypass_q       <= bypass_d;
      debug_select_q <= debug_select_d;
    end
  end

  // TDO launches on the falling edge so the receiver samples it on the next rising edge.
  always_ff @(negedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

endmodule

// File: tb/tb_adbg_jtag_tap.sv
// tb/tb_adbg_jtag_tap.sv - scoreboard bench for the JTAG TAP controller
module tb_adbg_jtag_tap;

  localparam int          IRW    = 4;
  localparam logic [31:0] IDCODE = 32'h149511C3;
  localparam logic [3:0]  I_IDC  = 4'b0010;
  localparam logic [3:0]  I_DBG  = 4'b1000;

  localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7,
                 UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

  int n0 [16] = '{RTI, RTI, CDR, SHDR, SHDR, PDR, PDR, SHDR, RTI, CIR, SHIR, SHIR, PIR, PIR, SHIR, RTI};
  int n1 [16] = '{TLR, SDR, SIR, E1DR, E1DR, UDR, E2DR, UDR, SDR, TLR, E1IR, E1IR, UIR, E2IR, UIR, SDR};

  logic tck = 1'b0;
  logic trstn = 1'b0;

  adbg_jtag_tap_if jif();

  adbg_jtag_tap dut (
    .tck_i   (tck),
    .trstn_i (trstn),
    .jtag    (jif)
  );

  always #5 tck = ~tck;

  int total = 0;
  int bad   = 0;

  int       m_st;
  logic [3:0] m_ir;
  bit       m_dsel;
  bit       ir_q[$];
  bit       dr_q[$];
  bit       exp_q[$];
  bit       seen_q[$];
  int       cnt_cap, cnt_sh, cnt_pau, cnt_upd;
  logic [31:0] idc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st   = TLR;
    m_ir   = I_IDC;
    m_dsel = 1'b0;
    ir_q.delete();
    dr_q.delete();
    exp_q.delete();
  endtask

  task automatic tick(input bit tms, input bit tdi);
    bit dtdo;
    logic [6:0] exp_v, act_v;
    dtdo = 1'($urandom);
    jif.tms_i       = tms;
    jif.tdi_i       = tdi;
    jif.debug_tdo_i = dtdo;
    case (m_st)
      CIR: begin
        ir_q.delete();
        ir_q.push_back(1'b1);
        for (int i = 1; i < IRW; i++) ir_q.push_back(1'b0);
      end
      SHIR: begin
        exp_q.push_back(ir_q.pop_front());
        ir_q.push_back(tdi);
      end
      CDR: begin
        dr_q.delete();
        if (m_ir == I_IDC) for (int i = 0; i < 32; i++) dr_q.push_back(idc[i]);
        else if (m_ir != I_DBG) dr_q.push_back(1'b0);
      end
      SHDR: begin
        if (m_ir == I_DBG) exp_q.push_back(dtdo);
        else begin
          exp_q.push_back(dr_q.pop_front());
          dr_q.push_back(tdi);
        end
      end
      UIR: for (int i = 0; i < IRW; i++) m_ir[i] = ir_q[i];
      default: ;
    endcase
    m_st = tms ? n1[m_st] : n0[m_st];
    if (m_st == TLR) m_ir = I_IDC;
    m_dsel = (m_ir == I_DBG);
    @(posedge tck);
    #1;
    exp_v = {m_st == TLR, m_st == RTI, m_st == SHDR, m_st == PDR, m_st == UDR, m_st == CDR, m_dsel};
    act_v = {jif.test_logic_reset_o, jif.run_test_idle_o, jif.shift_dr_o, jif.pause_dr_o,
             jif.update_dr_o, jif.capture_dr_o, jif.debug_select_o};
    check("strobes", 32'(act_v), 32'(exp_v));
    cnt_cap += int'(jif.capture_dr_o);
    cnt_sh  += int'(jif.shift_dr_o);
    cnt_pau += int'(jif.pause_dr_o);
    cnt_upd += int'(jif.update_dr_o);
  endtask

  task automatic load_ir(input logic [3:0] v);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < IRW; i++) tick(i == IRW - 1, v[i]);
    tick(1, 0); tick(0, 0);
  endtask

  task automatic shift_dr(input int n, input logic [63:0] data);
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < n; i++) tick(i == n - 1, data[i]);
    tick(1, 0); tick(0, 0);
  endtask

  // Compares each presented TDO bit with the oldest expectation queued by the stimulus.
  initial begin
    forever begin
      @(posedge tck);
      if (jif.tdo_oe_o === 1'b1) begin
        seen_q.push_back(jif.tdo_o);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tdo_unexpected: got %b expected no shift", jif.tdo_o);
        end else begin
          check("tdo", 32'(jif.tdo_o), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] got8;
    idc = IDCODE;
    jif.tms_i = 1'b1;
    jif.tdi_i = 1'b0;
    jif.debug_tdo_i = 1'b0;
    model_reset();
    #22;
    check("rst_tlr", 32'(jif.test_logic_reset_o), 32'd1);
    check("rst_other", 32'({jif.run_test_idle_o, jif.shift_dr_o, jif.pause_dr_o,
                            jif.update_dr_o, jif.capture_dr_o, jif.debug_select_o}), 32'd0);
    check("rst_tdo", 32'({jif.tdo_o, jif.tdo_oe_o}), 32'd0);
    trstn = 1'b1;

    tick(0, 0);
    check("rti", 32'({jif.run_test_idle_o, jif.debug_select_o}), 32'b10);
    shift_dr(32, 64'(32'hDEADBEEF));

    load_ir(I_DBG);
    check("dsel_after_upd", 32'(jif.debug_select_o), 32'd1);

    load_ir(4'b1111);
    seen_q.delete();
    shift_dr(8, 64'h00A5);
    for (int i = 0; i < 8; i++) got8[i] = seen_q[i];
    check("bypass_stream", 32'(got8), 32'h4A);

    load_ir(I_DBG);
    cnt_cap = 0; cnt_sh = 0; cnt_pau = 0; cnt_upd = 0;
    tick(1, 0); tick(0, 0); tick(0, 1);
    tick(0, 0); tick(0, 1); tick(1, 1);
    tick(0, 0); tick(1, 0); tick(0, 0);
    tick(1, 1); tick(1, 0); tick(0, 0);
    check("cnt_capture", 32'(cnt_cap), 32'd1);
    check("cnt_shift", 32'(cnt_sh), 32'd4);
    check("cnt_pause", 32'(cnt_pau), 32'd1);
    check("cnt_update", 32'(cnt_upd), 32'd1);

    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 5; i++) tick(1, 1'($urandom));
    check("tms5_tlr", 32'({jif.test_logic_reset_o, jif.debug_select_o}), 32'b10);
    tick(0, 0);
    seen_q.delete();
    shift_dr(32, 64'($urandom));
    for (int i = 0; i < 32; i++) check("idcode_bit", 32'(seen_q[i]), 32'(idc[i]));

    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 1); tick(0, 0);
    cnt_upd = 0;
    trstn = 1'b0;
    #1;
    check("midrst_tlr", 32'(jif.test_logic_reset_o), 32'd1);
    check("midrst_oe", 32'(jif.tdo_oe_o), 32'd0);
    model_reset();
    #2;
    trstn = 1'b1;
    tick(1, 0);
    tick(0, 0);
    shift_dr(32, 64'($urandom));
    check("midrst_no_upd", 32'(cnt_upd), 32'd1);

    for (int i = 0; i < 400; i++) tick($urandom_range(0, 2) == 0, 1'($urandom));
    for (int i = 0; i < 5; i++) tick(1, 0);
    @(posedge tck);
    #1;
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
